pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 255: MEM_WAIT cycle count that sets mem_timeout.
REQ-002 SHALL have parameter CNT_W, default 16: stall_count and flush_count width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 if_id_rs  input  5  rs field of the instruction in ID.
REQ-006 if_id_rt  input  5  rt field of the instruction in ID.
REQ-007 id_ex_memread  input  1  instruction in EX is a load.
REQ-008 id_ex_rt  input  5  destination register of the load in EX.
REQ-009 ex_branch_taken  input  1  branch in EX resolved taken this cycle.
REQ-010 mem_req  input  1  MEM stage is performing a data-memory access.
REQ-011 mem_ready  input  1  data memory completes the access this cycle.
REQ-012 pc_write  output  1  PC load enable.
REQ-013 if_id_write  output  1  IF/ID register load enable.
REQ-014 if_id_flush  output  1  IF/ID register loads a NOP.
REQ-015 id_ex_bubble  output  1  ID/EX register loads bubble controls instead of decoded controls.
REQ-016 id_ex_hold  output  1  ID/EX register keeps its contents.
REQ-017 ex_mem_hold  output  1  EX/MEM register keeps its contents.
REQ-018 state  output  2  current FSM state: RUN=0, FLUSH=1, MEM_WAIT=2.
REQ-019 stall_count  output  CNT_W  saturating count of cycles with pc_write=0.
REQ-020 flush_count  output  CNT_W  saturating count of branch flushes.
REQ-021 mem_timeout  output  1  sticky error: memory wait reached WAIT_LIMIT.

Function
REQ-022 Load-use hazard (LU) SHALL be id_ex_memread=1, id_ex_rt!=0, and id_ex_rt equal to if_id_rs or if_id_rt.
REQ-023 Memory stall (MS) SHALL be mem_req=1 and mem_ready=0.
REQ-024 Default outputs SHALL be: pc_write=1, if_id_write=1, all other control outputs 0.
REQ-025 Decode SHALL be combinational (Mealy) from state and inputs, with zero-cycle latency.
REQ-026 Priority SHALL be MS, then ex_branch_taken, then LU.
REQ-027 In RUN with MS, the block SHALL drive pc_write=0, if_id_write=0, id_ex_hold=1, ex_mem_hold=1, id_ex_bubble=0, and go to MEM_WAIT.
REQ-028 In RUN with branch taken and no MS, the block SHALL drive if_id_flush=1 and id_ex_bubble=1, go to FLUSH, and increment flush_count.
REQ-029 In RUN with LU only, the block SHALL drive pc_write=0, if_id_write=0, id_ex_bubble=1, and stay in RUN; the hazard clears after one cycle without extra state.
REQ-030 In FLUSH, the block SHALL drive id_ex_bubble=1 for one cycle, squashing the second wrong-path slot, then return to RUN; if MS is true in that cycle, the MS outputs apply and the next state is MEM_WAIT.
REQ-031 In MEM_WAIT while mem_ready=0, the block SHALL hold the MS outputs and increment an internal wait counter (width log2(WAIT_LIMIT+1)) that saturates at WAIT_LIMIT.
REQ-032 In MEM_WAIT, the cycle mem_ready=1 SHALL release: default outputs, next state RUN, in that same cycle.
REQ-033 The wait counter SHALL clear on entry to MEM_WAIT.
REQ-034 mem_timeout SHALL set on the cycle the wait counter reaches WAIT_LIMIT and stay set until rst.
REQ-035 A branch taken during MS SHALL be ignored: EX is held, so the branch re-presents after release.
REQ-036 stall_count SHALL increment every cycle pc_write=0, saturating at all-ones.
REQ-037 flush_count SHALL increment once per FLUSH entry, saturating at all-ones.
REQ-038 if_id_flush and if_id_write SHALL never both be 0 in a flush cycle; if_id_flush=1 implies if_id_write=1.

Reset
REQ-039 While rst=1, the block SHALL set state=RUN, stall_count=0, flush_count=0, wait counter=0, mem_timeout=0.
REQ-040 While rst=1, the block SHALL force pc_write=0, if_id_write=0, and all other control outputs to 0.
REQ-041 rst asserted mid-MEM_WAIT or mid-FLUSH SHALL abort immediately; after rst is released, the first cycle is in RUN.

Verification
REQ-042 Load-use: id_ex_memread=1, id_ex_rt=5, if_id_rs=5 for 1 cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle; stall_count=1; state stays 0.
REQ-043 $zero exemption: same as REQ-042 but id_ex_rt=0, if_id_rt=0 -> default outputs; stall_count unchanged.
REQ-044 Branch: ex_branch_taken=1 one cycle -> if_id_flush=1, id_ex_bubble=1; next cycle state=1, id_ex_bubble=1 only; then state=0; flush_count=1.
REQ-045 Memory wait: mem_req=1, mem_ready=0 for 4 cycles, then 1 -> four frozen cycles with holds=1; release on cycle 5; stall_count=4.
REQ-046 Simultaneous and timeout: MS + branch + LU together -> MS outputs only, flush_count=0; holding mem_ready=0 for 255 cycles -> mem_timeout=1, which persists after release until rst.
REQ-047 Reset mid-wait: rst pulse in MEM_WAIT -> state=0, counters=0, mem_timeout=0, all enables 0 during rst.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and
// data-memory wait handling for a classic 5-stage pipeline.
module pipe_hazard_ctrl #(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             id_ex_hold,
    output logic             ex_mem_hold,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);

    localparam int WW = $clog2(WAIT_LIMIT + 1);
    localparam logic [WW-1:0] LIM = WW'(WAIT_LIMIT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WW-1:0]    r_wait;
    logic [WW-1:0]    w_wait_nxt;
    logic             r_timeout;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_lu;
    logic             w_ms;
    logic             w_flush_entry;
    logic             w_wait_entry;

    assign w_ms = mem_req & ~mem_ready;
    assign w_lu = id_ex_memread && (id_ex_rt != 5'd0) &&
                  ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

    always_comb begin
        w_next       = r_state;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        id_ex_hold   = 1'b0;
        ex_mem_hold  = 1'b0;
        if (rst) begin
            w_next      = RUN;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (w_ms) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_hold  = 1'b1;
                        ex_mem_hold = 1'b1;
                        w_next      = MEM_WAIT;
                    end else if (ex_branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        w_next       = FLUSH;
                    end else if (w_lu) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                end
                FLUSH: begin
                    if (w_ms) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_hold  = 1'b1;
                        ex_mem_hold = 1'b1;
                        w_next      = MEM_WAIT;
                    end else begin
                        id_ex_bubble = 1'b1;
                        w_next       = RUN;
                    end
                end
                MEM_WAIT: begin
                    // release is combinational on the ready cycle
                    if (mem_ready) begin
                        w_next = RUN;
                    end else begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_hold  = 1'b1;
                        ex_mem_hold = 1'b1;
                    end
                end
                default: w_next = RUN;
            endcase
        end
    end

    assign w_flush_entry = (r_state == RUN) && (w_next == FLUSH);
    assign w_wait_entry  = (r_state != MEM_WAIT) && (w_next == MEM_WAIT);

    always_comb begin
        w_wait_nxt = r_wait;
        if (w_wait_entry) begin
            w_wait_nxt = '0;
        end else if ((r_state == MEM_WAIT) && !mem_ready &&
                     (r_wait != LIM)) begin
            w_wait_nxt = r_wait + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_wait      <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_nxt;
            if ((r_state == MEM_WAIT) && (w_wait_nxt == LIM)) begin
                r_timeout <= 1'b1;
            end
            if (!pc_write && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_entry && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign state       = r_state;
    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;
    assign mem_timeout = r_timeout;

endmodule
